// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer with a 13-bit PC.
// Optional retired-instruction counter enabled by FETCH_SEQ_INSTR_COUNT_EN.
module fetch_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        halt_instr,
   input  logic        stall,
   input  logic [2:0]  branch,
   input  logic        jump,
   input  logic [12:0] pda,
   input  logic [12:0] rs_out,
   input  logic [12:0] offset,
   output logic [12:0] pc,
   output logic        imem_en,
   output logic        ir_load,
   output logic        reg_write_en,
   output logic [2:0]  state,
   output logic        running
`ifdef FETCH_SEQ_INSTR_COUNT_EN
   ,
   output logic [15:0] instr_count
`endif
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'b000,
      S_FETCH  = 3'b001,
      S_DECODE = 3'b010,
      S_EXEC   = 3'b011,
      S_WB     = 3'b100,
      S_HALT   = 3'b101
   } state_t;

   state_t      state_r;
   state_t      state_next_s;
   logic [12:0] pc_r;
   logic [12:0] pc_next_s;
   logic        imem_en_r;
   logic        ir_load_r;
   logic        reg_write_en_r;
   logic        running_r;

   // Next-state decode.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               state_next_s = S_FETCH;
            end else begin
               state_next_s = S_IDLE;
            end
         end
         S_FETCH:  state_next_s = S_DECODE;
         S_DECODE: begin
            if (halt_instr) begin
               state_next_s = S_HALT;
            end else begin
               state_next_s = S_EXEC;
            end
         end
         S_EXEC: begin
            if (stall) begin
               state_next_s = S_EXEC;
            end else begin
               state_next_s = S_WB;
            end
         end
         S_WB:     state_next_s = S_FETCH;
         S_HALT:   state_next_s = S_HALT;
         default:  state_next_s = S_IDLE;
      endcase
   end

   // Next-PC select; branch/jump are only looked at in WB.
   always_comb begin
      pc_next_s = pc_r;
      if (state_r == S_WB) begin
         if (branch == 3'b001) begin
            pc_next_s = pda;
         end else if (branch == 3'b010) begin
            pc_next_s = rs_out;
         end else if (jump) begin
            pc_next_s = offset;
         end else begin
            pc_next_s = pc_r + 13'd4;
         end
      end else begin
         pc_next_s = pc_r;
      end
   end

   // State, PC and strobe registers; strobes are decoded from the next state
   // so they line up with the state they belong to.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= S_IDLE;
         pc_r           <= 13'd0;
         imem_en_r      <= 1'b0;
         ir_load_r      <= 1'b0;
         reg_write_en_r <= 1'b0;
         running_r      <= 1'b0;
      end else begin
         state_r        <= state_next_s;
         pc_r           <= pc_next_s;
         imem_en_r      <= (state_next_s == S_FETCH);
         ir_load_r      <= (state_next_s == S_DECODE);
         reg_write_en_r <= (state_next_s == S_WB);
         running_r      <= (state_next_s != S_IDLE) && (state_next_s != S_HALT);
      end
   end

`ifdef FETCH_SEQ_INSTR_COUNT_EN
   logic [15:0] instr_count_r;

   // Retired-instruction counter, bumps once per writeback and wraps.
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_count_r <= 16'd0;
      end else if (state_r == S_WB) begin
         instr_count_r <= instr_count_r + 16'd1;
      end else begin
         instr_count_r <= instr_count_r;
      end
   end

   assign instr_count = instr_count_r;
`endif

   assign pc           = pc_r;
   assign imem_en      = imem_en_r;
   assign ir_load      = ir_load_r;
   assign reg_write_en = reg_write_en_r;
   assign state        = state_r;
   assign running      = running_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer.
`timescale 1ns/1ps
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        halt_instr;
   logic        stall;
   logic [2:0]  branch;
   logic        jump;
   logic [12:0] pda;
   logic [12:0] rs_out;
   logic [12:0] offset;
   logic [12:0] pc;
   logic        imem_en;
   logic        ir_load;
   logic        reg_write_en;
   logic [2:0]  state;
   logic        running;
`ifdef FETCH_SEQ_INSTR_COUNT_EN
   logic [15:0] instr_count;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   logic [12:0] exp_pc;

   fetch_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .halt_instr(halt_instr),
      .stall(stall), .branch(branch), .jump(jump), .pda(pda),
      .rs_out(rs_out), .offset(offset), .pc(pc), .imem_en(imem_en),
      .ir_load(ir_load), .reg_write_en(reg_write_en), .state(state),
      .running(running)
`ifdef FETCH_SEQ_INSTR_COUNT_EN
      , .instr_count(instr_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_strobes(input string tag, input logic fe, input logic de, input logic wb);
      check({tag, "_imem_en"}, {31'd0, imem_en}, {31'd0, fe});
      check({tag, "_ir_load"}, {31'd0, ir_load}, {31'd0, de});
      check({tag, "_reg_we"}, {31'd0, reg_write_en}, {31'd0, wb});
   endtask

   // Runs one instruction from FETCH back to FETCH. Garbage branch/jump values
   // are driven outside WB to show they are ignored there.
   task automatic do_instr(input logic [2:0] br, input logic jp, input logic [12:0] next_pc);
      branch = 3'b001; jump = 1'b1;
      tick();
      check("dec_state", {29'd0, state}, 32'd2);
      check_strobes("dec", 1'b0, 1'b1, 1'b0);
      check("dec_pc", {19'd0, pc}, {19'd0, exp_pc});
      tick();
      check("exec_state", {29'd0, state}, 32'd3);
      check_strobes("exec", 1'b0, 1'b0, 1'b0);
      check("exec_pc", {19'd0, pc}, {19'd0, exp_pc});
      tick();
      check("wb_state", {29'd0, state}, 32'd4);
      check_strobes("wb", 1'b0, 1'b0, 1'b1);
      check("wb_pc", {19'd0, pc}, {19'd0, exp_pc});
      branch = br; jump = jp;
      tick();
      exp_pc = next_pc;
      check("fetch_state", {29'd0, state}, 32'd1);
      check_strobes("fetch", 1'b1, 1'b0, 1'b0);
      check("fetch_pc", {19'd0, pc}, {19'd0, exp_pc});
      check("fetch_running", {31'd0, running}, 32'd1);
      branch = 3'b000; jump = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; halt_instr = 1'b0; stall = 1'b0;
      branch = 3'b000; jump = 1'b0; pda = 13'h0100; rs_out = 13'h1FFC; offset = 13'h0020;
      exp_pc = 13'd0;
      tick(); tick();
      rst = 1'b0;
      tick();
      check("rst_state", {29'd0, state}, 32'd0);
      check("rst_pc", {19'd0, pc}, 32'd0);
      check_strobes("rst", 1'b0, 1'b0, 1'b0);
      check("rst_running", {31'd0, running}, 32'd0);
`ifdef FETCH_SEQ_INSTR_COUNT_EN
      check("rst_count", {16'd0, instr_count}, 32'd0);
`endif
      tick();
      check("idle_hold", {29'd0, state}, 32'd0);

      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_state", {29'd0, state}, 32'd1);
      check_strobes("start", 1'b1, 1'b0, 1'b0);
      check("start_pc", {19'd0, pc}, 32'd0);

      // Three sequential instructions.
      do_instr(3'b000, 1'b0, 13'd4);
      do_instr(3'b000, 1'b0, 13'd8);
      do_instr(3'b000, 1'b0, 13'd12);
      // Absolute wins over jump, then jump alone, then register wins over jump.
      do_instr(3'b001, 1'b1, 13'h0100);
      do_instr(3'b000, 1'b1, 13'h0020);
      do_instr(3'b010, 1'b1, 13'h1FFC);
      // Sequential wrap at the top of the address space.
      do_instr(3'b000, 1'b0, 13'd0);

      // Stall holds EXEC for six cycles.
      tick();
      check("st_dec", {29'd0, state}, 32'd2);
      stall = 1'b1;
      tick();
      check("st_exec0", {29'd0, state}, 32'd3);
      for (int i = 0; i < 5; i++) begin
         start = 1'b1;
         tick();
         check("st_exec", {29'd0, state}, 32'd3);
         check("st_pc", {19'd0, pc}, 32'd0);
         check("st_reg_we", {31'd0, reg_write_en}, 32'd0);
      end
      stall = 1'b0; start = 1'b0;
      tick();
      check("st_wb", {29'd0, state}, 32'd4);
      tick();
      check("st_fetch", {29'd0, state}, 32'd1);
      check("st_pc_next", {19'd0, pc}, 32'd4);

      // Halt is absorbing.
      tick();
      halt_instr = 1'b1;
      tick();
      halt_instr = 1'b0;
      check("halt_state", {29'd0, state}, 32'd5);
      check("halt_running", {31'd0, running}, 32'd0);
      check_strobes("halt", 1'b0, 1'b0, 1'b0);
`ifdef FETCH_SEQ_INSTR_COUNT_EN
      check("halt_count", {16'd0, instr_count}, 32'd8);
`endif
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("halt_start", {29'd0, state}, 32'd5);
      check("halt_pc", {19'd0, pc}, 32'd4);
`ifdef FETCH_SEQ_INSTR_COUNT_EN
      check("halt_count_hold", {16'd0, instr_count}, 32'd8);
`endif
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("halt_rst_state", {29'd0, state}, 32'd0);
      check("halt_rst_pc", {19'd0, pc}, 32'd0);

      // Reset in WB beats the register-target update.
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      check("rwb_state", {29'd0, state}, 32'd4);
      check("rwb_we", {31'd0, reg_write_en}, 32'd1);
      branch = 3'b010; rs_out = 13'h0040; rst = 1'b1;
      tick();
      rst = 1'b0; branch = 3'b000;
      check("rwb_pc", {19'd0, pc}, 32'd0);
      check("rwb_reg_we", {31'd0, reg_write_en}, 32'd0);
      check("rwb_state_idle", {29'd0, state}, 32'd0);
      check("rwb_running", {31'd0, running}, 32'd0);
`ifdef FETCH_SEQ_INSTR_COUNT_EN
      check("rwb_count", {16'd0, instr_count}, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The port clk, input, 1 bit, SHALL be the single clock; every register updates on its rising edge.
REQ-002 The port rst, input, 1 bit, SHALL be the reset: synchronous and active-high.
REQ-003 The port start, input, 1 bit, SHALL be a one-cycle pulse that begins execution from IDLE.
REQ-004 The port halt_instr, input, 1 bit, SHALL be the decoded-halt flag; it is sampled in DECODE.
REQ-005 The port stall, input, 1 bit, SHALL indicate a multi-cycle ALU op; it holds EXEC while high.
REQ-006 The port branch, input, 3 bits, SHALL be the next-PC select: 001 absolute, 010 register, others sequential/conditional.
REQ-007 The port jump, input, 1 bit, SHALL be the resolved branch-taken flag.
REQ-008 The ports pda, rs_out and offset, inputs, 13 bits each, SHALL carry the absolute target, the register target and the taken-branch target.
REQ-009 The port pc, output, 13 bits, SHALL be the current instruction address.
REQ-010 The port imem_en, output, 1 bit, SHALL be the instruction-memory read enable.
REQ-011 The port ir_load, output, 1 bit, SHALL load the instruction register.
REQ-012 The port reg_write_en, output, 1 bit, SHALL be the register-file write strobe.
REQ-013 The port state, output, 3 bits, SHALL expose the FSM state encoding.
REQ-014 The port running, output, 1 bit, SHALL be high in every state except IDLE and HALT.

Function
REQ-015 The FSM SHALL use these state encodings: IDLE=000, FETCH=001, DECODE=010, EXEC=011, WB=100, HALT=101.
REQ-016 IDLE SHALL move to FETCH on start; otherwise it SHALL hold.
REQ-017 FETCH SHALL assert imem_en for exactly one cycle, then move to DECODE (memory latency is one cycle).
REQ-018 DECODE SHALL assert ir_load for one cycle, then move to HALT if halt_instr=1, else to EXEC.
REQ-019 EXEC SHALL remain in EXEC while stall=1 and SHALL move to WB in the first cycle with stall=0.
REQ-020 WB SHALL assert reg_write_en for one cycle, update pc, then move to FETCH.
REQ-021 Next-PC selection in WB SHALL follow this priority:
- branch==001 -> pda
- branch==010 -> rs_out
- jump=1 -> offset
- otherwise -> pc+4
REQ-022 The pc+4 computation SHALL be modulo 2^13: pc=8188 wraps to 0.
REQ-023 pc SHALL change only in WB (or at reset); it SHALL be stable in all other states.
REQ-024 branch and jump SHALL be sampled only in the WB cycle; changes in other states SHALL be ignored.
REQ-025 start SHALL be ignored in every state except IDLE.
REQ-026 HALT SHALL be absorbing; only rst leaves it.
REQ-027 imem_en, ir_load and reg_write_en SHALL be mutually exclusive and SHALL all be low in IDLE, EXEC and HALT.
REQ-028 Simultaneous branch==001 and jump=1 SHALL select pda.

Reset
REQ-029 When rst=1 at a clock edge, the block SHALL set state=IDLE, pc=0, imem_en=0, ir_load=0, reg_write_en=0 and running=0.
REQ-030 rst SHALL take priority over start, stall and every state transition, including reset mid-EXEC or mid-WB; no write strobe SHALL issue in the reset cycle.

Configuration
REQ-031 When the macro FETCH_SEQ_INSTR_COUNT_EN is defined, the block SHALL add the output instr_count, 16 bits, which:
- increments by 1 on every WB cycle;
- wraps from 65535 to 0;
- is cleared by rst;
- holds in IDLE and HALT.
REQ-032 When FETCH_SEQ_INSTR_COUNT_EN is undefined, the instr_count port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 Reset then start, with branch=000 and jump=0 for three instructions -> states cycle 001,010,011,100 repeatedly; pc sequence is 0,4,8,12.
REQ-034 In WB, branch=001, jump=1, pda=0x0100, offset=0x0020 -> pc=0x0100 in the next cycle.
REQ-035 Hold stall=1 for 5 cycles in EXEC -> state stays 011 for 6 cycles, pc unchanged, no reg_write_en during the stall.
REQ-036 pc=8188 with sequential flow -> pc=0 after WB.
REQ-037 halt_instr=1 in DECODE -> state=101 and running=0; a later start pulse has no effect; rst returns the block to state=000 with pc=0.
REQ-038 Assert rst during WB with branch=010 and rs_out=0x0040 -> pc=0, reg_write_en=0; with FETCH_SEQ_INSTR_COUNT_EN defined, instr_count=0.
